// File: rtl/instruction_encoder.sv
// RV32I instruction encoder: packs a field set into a 32-bit instruction word
// behind a valid/ready handshake, flags unrepresentable immediates, and counts
// delivered words.
// Optional feature: define INSTR_ENCODER_LI_EN to expand the LI pseudo
// instruction (in_type 6) into ADDI or LUI+ADDI; otherwise type 6 is reserved.
`timescale 1ns/1ps

module instruction_encoder (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [2:0]  in_type,
   input  logic [6:0]  in_opcode,
   input  logic [2:0]  in_funct3,
   input  logic [6:0]  in_funct7,
   input  logic [4:0]  in_rd,
   input  logic [4:0]  in_rs1,
   input  logic [4:0]  in_rs2,
   input  logic [31:0] in_imm,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instruction,
   output logic        out_error,
   output logic [15:0] out_count
);

   localparam int unsigned XLEN  = 32;
   localparam int unsigned CNT_W = 16;

   localparam logic [2:0] T_R  = 3'd0;
   localparam logic [2:0] T_I  = 3'd1;
   localparam logic [2:0] T_S  = 3'd2;
   localparam logic [2:0] T_SB = 3'd3;
   localparam logic [2:0] T_U  = 3'd4;
   localparam logic [2:0] T_UJ = 3'd5;
`ifdef INSTR_ENCODER_LI_EN
   localparam logic [2:0] T_LI = 3'd6;
   localparam logic [6:0] OP_LUI = 7'h37;
`endif

   localparam logic [6:0]      OP_OPIMM = 7'h13;
   localparam logic [XLEN-1:0] NOP_WORD = 32'h0000_0013;

   typedef enum logic {
      SINGLE = 1'b0,
      LI_HI  = 1'b1
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [XLEN-1:0]   li_lo;
   logic [XLEN-1:0]   li_lo_nxt;
   logic              out_valid_nxt;
   logic [XLEN-1:0]   out_instruction_nxt;
   logic              out_error_nxt;
   logic [CNT_W-1:0]  out_count_nxt;

   logic [6:0]        op;
   logic              fits12;
   logic              fits13;
   logic              fits21;
   logic [XLEN-1:0]   enc_word;
   logic              enc_err;
   logic              enc_two;
   logic [XLEN-1:0]   enc_lo;
   logic              in_fire;
   logic              out_fire;

   // Opcode low bits are always 2'b11 in RV32I; OR-ing keeps every input bit live.
   assign op     = in_opcode | 7'b000_0011;
   assign fits12 = (in_imm == {{20{in_imm[11]}}, in_imm[11:0]});
   assign fits13 = (in_imm == {{19{in_imm[12]}}, in_imm[12:0]});
   assign fits21 = (in_imm == {{11{in_imm[20]}}, in_imm[20:0]});

`ifdef INSTR_ENCODER_LI_EN
   logic [19:0] lui_hi;
   // Upper part rounds up when the low 12 bits are negative as a signed ADDI operand.
   assign lui_hi = in_imm[31:12] + 20'(in_imm[11]);
`endif

   // Handshake qualifiers; the encoder only accepts in SINGLE and never in reset.
   assign in_ready = rst_n && (state == SINGLE) && (!out_valid || out_ready);
   assign in_fire  = in_valid && in_ready;
   assign out_fire = out_valid && out_ready;

   // Field packing and immediate range checks for the presented field set.
   always_comb begin
      enc_word = NOP_WORD;
      enc_err  = 1'b0;
      enc_two  = 1'b0;
      enc_lo   = '0;
      case (in_type)
         T_R: begin
            enc_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, op};
         end
         T_I: begin
            enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, op};
            enc_err  = !fits12;
         end
         T_S: begin
            enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], op};
            enc_err  = !fits12;
         end
         T_SB: begin
            enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                        in_imm[4:1], in_imm[11], op};
            enc_err  = !fits13 || in_imm[0];
         end
         T_U: begin
            enc_word = {in_imm[31:12], in_rd, op};
            enc_err  = |in_imm[11:0];
         end
         T_UJ: begin
            enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, op};
            enc_err  = !fits21 || in_imm[0];
         end
`ifdef INSTR_ENCODER_LI_EN
         T_LI: begin
            if (fits12) begin
               enc_word = {in_imm[11:0], 5'd0, 3'd0, in_rd, OP_OPIMM};
            end else begin
               enc_word = {lui_hi, in_rd, OP_LUI};
               enc_two  = 1'b1;
               enc_lo   = {in_imm[11:0], in_rd, 3'd0, in_rd, OP_OPIMM};
            end
         end
`endif
         default: begin
            enc_word = NOP_WORD;
            enc_err  = 1'b1;
         end
      endcase
   end

   // Next-state and next-output logic: load on acceptance, hold until taken.
   always_comb begin
      state_nxt           = state;
      li_lo_nxt           = li_lo;
      out_valid_nxt       = out_valid;
      out_instruction_nxt = out_instruction;
      out_error_nxt       = out_error;
      out_count_nxt       = out_count + CNT_W'(out_fire);

      if (out_fire) begin
         out_valid_nxt = 1'b0;
      end

      case (state)
         SINGLE: begin
            if (in_fire) begin
               out_valid_nxt       = 1'b1;
               out_instruction_nxt = enc_word;
               out_error_nxt       = enc_err;
               if (enc_two) begin
                  li_lo_nxt = enc_lo;
                  state_nxt = LI_HI;
               end
            end
         end
         LI_HI: begin
            if (out_fire) begin
               out_valid_nxt       = 1'b1;
               out_instruction_nxt = li_lo;
               out_error_nxt       = 1'b0;
               state_nxt           = SINGLE;
            end
         end
         default: begin
            state_nxt = SINGLE;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state           <= SINGLE;
         li_lo           <= '0;
         out_valid       <= 1'b0;
         out_instruction <= '0;
         out_error       <= 1'b0;
         out_count       <= '0;
      end else begin
         state           <= state_nxt;
         li_lo           <= li_lo_nxt;
         out_valid       <= out_valid_nxt;
         out_instruction <= out_instruction_nxt;
         out_error       <= out_error_nxt;
         out_count       <= out_count_nxt;
      end
   end

endmodule

// File: tb/tb_instruction_encoder.sv
// Self-checking bench for instruction_encoder: expected {error, word} pairs are
// queued at input acceptance and compared as each word is handed to the consumer.
`timescale 1ns/1ps

module tb_instruction_encoder;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_type;
   logic [6:0]  in_opcode;
   logic [2:0]  in_funct3;
   logic [6:0]  in_funct7;
   logic [4:0]  in_rd;
   logic [4:0]  in_rs1;
   logic [4:0]  in_rs2;
   logic [31:0] in_imm;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instruction;
   logic        out_error;
   logic [15:0] out_count;

   int          pass_cnt;
   int          total_cnt;
   int          model_count;
   bit          accepted;
   logic [32:0] exp_q[$];
   logic [32:0] drv_exp[$];

   instruction_encoder dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .in_type         (in_type),
      .in_opcode       (in_opcode),
      .in_funct3       (in_funct3),
      .in_funct7       (in_funct7),
      .in_rd           (in_rd),
      .in_rs1          (in_rs1),
      .in_rs2          (in_rs2),
      .in_imm          (in_imm),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_instruction (out_instruction),
      .out_error       (out_error),
      .out_count       (out_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One clock: pop/compare a delivered word, queue expectations for an accepted input.
   task automatic step();
      logic [32:0] e;
      @(negedge clk);
      accepted = 1'b0;
      if (out_valid && out_ready) begin
         model_count++;
         total_cnt++;
         if (exp_q.size() == 0) begin
            $display("FAIL word_unexpected got=%h err=%b expected none", out_instruction, out_error);
         end else begin
            e = exp_q.pop_front();
            if ({out_error, out_instruction} !== e)
               $display("FAIL word got=%h err=%b expected=%h err=%b",
                        out_instruction, out_error, e[31:0], e[32]);
            else
               pass_cnt++;
         end
      end
      if (in_valid && in_ready) begin
         foreach (drv_exp[i]) exp_q.push_back(drv_exp[i]);
         accepted = 1'b1;
      end
      @(posedge clk);
      #1;
   endtask

   // Present a field set and clock until it is accepted (in_valid left high).
   task automatic send(input logic [2:0] t, input logic [6:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [31:0] imm,
                       input logic [32:0] e0, input logic [32:0] e1, input bit two);
      in_type   = t;
      in_opcode = op;
      in_funct3 = f3;
      in_funct7 = f7;
      in_rd     = rd;
      in_rs1    = rs1;
      in_rs2    = rs2;
      in_imm    = imm;
      drv_exp.delete();
      drv_exp.push_back(e0);
      if (two) drv_exp.push_back(e1);
      in_valid = 1'b1;
      accepted = 1'b0;
      for (int c = 0; c < 20 && !accepted; c++) step();
      total_cnt++;
      if (!accepted) $display("FAIL accept_timeout type=%0d not accepted within 20 cycles", t);
      else pass_cnt++;
   endtask

   // Stop offering input and let every queued word drain.
   task automatic drain();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < 20 && exp_q.size() != 0; c++) step();
      total_cnt++;
      if (exp_q.size() != 0) $display("FAIL drain_timeout remaining=%0d expected 0", exp_q.size());
      else pass_cnt++;
   endtask

   task automatic apply_reset();
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      @(negedge clk);
      total_cnt++;
      if (in_ready !== 1'b0) $display("FAIL in_ready_in_reset got=%b expected 0", in_ready);
      else pass_cnt++;
      @(posedge clk); #1;
      @(posedge clk); #1;
      exp_q.delete();
      model_count = 0;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      apply_reset();
      total_cnt++;
      if ({out_valid, out_instruction, out_error, out_count} !== 50'd0)
         $display("FAIL reset_state got v=%b w=%h e=%b c=%0d expected all zero",
                  out_valid, out_instruction, out_error, out_count);
      else pass_cnt++;
   endtask

   task automatic test_r_type();
      out_ready = 1'b1;
      // add x3,x1,x2 with opcode low bits cleared on input
      send(3'd0, 7'h30, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'd0, {1'b0, 32'h002081B3}, '0, 1'b0);
      in_valid = 1'b0;
      total_cnt++;
      if (out_valid !== 1'b1 || out_instruction !== 32'h002081B3 || out_error !== 1'b0)
         $display("FAIL r_latency got v=%b w=%h e=%b expected v=1 w=002081b3 e=0",
                  out_valid, out_instruction, out_error);
      else pass_cnt++;
      drain();
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1;
      send(3'd0, 7'h33, 3'd0, 7'h20, 5'd3, 5'd1, 5'd2, 32'd0,          {1'b0, 32'h402081B3}, '0, 1'b0);
      send(3'd1, 7'h13, 3'd0, 7'h00, 5'd5, 5'd6, 5'd0, 32'hFFFF_FFFF,  {1'b0, 32'hFFF30293}, '0, 1'b0);
      send(3'd1, 7'h13, 3'd0, 7'h00, 5'd5, 5'd6, 5'd0, 32'h0000_0800,  {1'b1, 32'h80030293}, '0, 1'b0);
      send(3'd2, 7'h23, 3'd2, 7'h00, 5'd0, 5'd1, 5'd2, 32'd8,          {1'b0, 32'h0020A423}, '0, 1'b0);
      send(3'd4, 7'h37, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h1234_5000,  {1'b0, 32'h123452B7}, '0, 1'b0);
      send(3'd4, 7'h37, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h1234_5001,  {1'b1, 32'h123452B7}, '0, 1'b0);
      send(3'd5, 7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd8,          {1'b0, 32'h008000EF}, '0, 1'b0);
      send(3'd5, 7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd9,          {1'b1, 32'h008000EF}, '0, 1'b0);
      send(3'd5, 7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'h0010_0000,  {1'b1, 32'h800000EF}, '0, 1'b0);
      drain();
   endtask

   task automatic test_sb();
      out_ready = 1'b1;
      send(3'd3, 7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC,  {1'b0, 32'hFE208EE3}, '0, 1'b0);
      send(3'd3, 7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'd3,          {1'b1, 32'h00208163}, '0, 1'b0);
      send(3'd3, 7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'h0000_1000,  {1'b1, 32'h80208063}, '0, 1'b0);
      drain();
   endtask

   task automatic test_reserved();
      out_ready = 1'b1;
      send(3'd7, 7'h33, 3'd1, 7'h7F, 5'd9, 5'd9, 5'd9, 32'h1234_5678,  {1'b1, 32'h00000013}, '0, 1'b0);
`ifndef INSTR_ENCODER_LI_EN
      send(3'd6, 7'h33, 3'd1, 7'h7F, 5'd5, 5'd0, 5'd0, 32'h1234_5FFF,  {1'b1, 32'h00000013}, '0, 1'b0);
`endif
      drain();
   endtask

`ifdef INSTR_ENCODER_LI_EN
   task automatic test_li();
      out_ready = 1'b1;
      send(3'd6, 7'h00, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'hFFFF_FFFB, {1'b0, 32'hFFB00293}, '0, 1'b0);
      send(3'd6, 7'h00, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h1234_5FFF,
           {1'b0, 32'h123462B7}, {1'b0, 32'hFFF28293}, 1'b1);
      in_valid = 1'b0;
      total_cnt++;
      if (in_ready !== 1'b0) $display("FAIL li_hi_in_ready got=%b expected 0", in_ready);
      else pass_cnt++;
      send(3'd6, 7'h00, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'd2047,      {1'b0, 32'h7FF00293}, '0, 1'b0);
      send(3'd6, 7'h00, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'd2048,
           {1'b0, 32'h000012B7}, {1'b0, 32'h80028293}, 1'b1);
      drain();
   endtask
`endif

   task automatic test_stall();
      int c0;
      out_ready = 1'b0;
      c0 = model_count;
      send(3'd0, 7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'd0, {1'b0, 32'h002081B3}, '0, 1'b0);
      // offer a different field set while the consumer stalls
      in_type = 3'd7;
      drv_exp.delete();
      drv_exp.push_back({1'b1, 32'h00000013});
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         total_cnt++;
         if (out_valid !== 1'b1 || out_instruction !== 32'h002081B3 || out_error !== 1'b0 ||
             in_ready !== 1'b0 || out_count !== 16'(c0))
            $display("FAIL stall_hold cyc=%0d got v=%b w=%h e=%b rdy=%b c=%0d expected v=1 w=002081b3 e=0 rdy=0 c=%0d",
                     i, out_valid, out_instruction, out_error, in_ready, out_count, c0);
         else pass_cnt++;
         @(posedge clk); #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      total_cnt++;
      if (out_count !== 16'(c0 + 1)) $display("FAIL stall_release_count got=%0d expected=%0d", out_count, c0 + 1);
      else pass_cnt++;
      drain();
   endtask

   task automatic test_count_wrap();
      int acc;
      int cyc;
      apply_reset();
      out_ready = 1'b1;
      in_type   = 3'd0;
      in_opcode = 7'h33;
      in_valid  = 1'b1;
      acc = 0;
      cyc = 0;
      while (model_count < 65535 && cyc < 70000) begin
         @(negedge clk);
         if (out_valid && out_ready) model_count++;
         if (in_valid && in_ready) acc++;
         @(posedge clk); #1;
         if (acc >= 65535) in_valid = 1'b0;
         cyc++;
      end
      in_valid = 1'b0;
      total_cnt++;
      if (model_count != 65535 || out_count !== 16'hFFFF)
         $display("FAIL count_preset got=%0d transfers=%0d expected 65535", out_count, model_count);
      else pass_cnt++;
      send(3'd0, 7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'd0, {1'b0, 32'h002081B3}, '0, 1'b0);
      drain();
      total_cnt++;
      if (out_count !== 16'h0000) $display("FAIL count_wrap got=%0d expected 0", out_count);
      else pass_cnt++;
   endtask

   task automatic test_reset_pending();
      out_ready = 1'b0;
`ifdef INSTR_ENCODER_LI_EN
      send(3'd6, 7'h00, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h1234_5FFF,
           {1'b0, 32'h123462B7}, {1'b0, 32'hFFF28293}, 1'b1);
`else
      send(3'd0, 7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'd0, {1'b0, 32'h002081B3}, '0, 1'b0);
`endif
      in_valid = 1'b0;
      total_cnt++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1)
         $display("FAIL pending_before_reset got rdy=%b v=%b expected rdy=0 v=1", in_ready, out_valid);
      else pass_cnt++;
      apply_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) step();
      total_cnt++;
      if (out_valid !== 1'b0 || out_count !== 16'h0000)
         $display("FAIL reset_abandon got v=%b c=%0d expected v=0 c=0", out_valid, out_count);
      else pass_cnt++;
   endtask

   initial begin
      pass_cnt    = 0;
      total_cnt   = 0;
      model_count = 0;
      rst_n       = 1'b0;
      in_valid    = 1'b0;
      out_ready   = 1'b0;
      in_type     = '0;
      in_opcode   = '0;
      in_funct3   = '0;
      in_funct7   = '0;
      in_rd       = '0;
      in_rs1      = '0;
      in_rs2      = '0;
      in_imm      = '0;
      test_reset();
      test_r_type();
      test_back_to_back();
      test_sb();
      test_reserved();
`ifdef INSTR_ENCODER_LI_EN
      test_li();
`endif
      test_stall();
      test_reset_pending();
      test_count_wrap();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/instruction_encoder.md
INSTRUCTION_ENCODER -- requirements
Module: instruction_encoder

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all logic on rising edge.
REQ-002 SHALL have ports: rst_n  in  1  reset, synchronous, active-low.
REQ-003 SHALL have ports: in_valid  in  1  input field set valid.
REQ-004 SHALL have ports: in_ready  out  1  encoder accepts the field set this cycle.
REQ-005 SHALL have ports: in_type  in  3  0=R, 1=I, 2=S, 3=SB, 4=U, 5=UJ, 6=LI (pseudo), 7=reserved.
REQ-006 SHALL have ports: in_opcode  in  7  opcode, bits [1:0] forced to 2'b11 on output; ignored for LI.
REQ-007 SHALL have ports: in_funct3 in 3, in_funct7 in 7, in_rd in 5, in_rs1 in 5, in_rs2 in 5, in_imm in 32 (immediate, sign-meaningful).
REQ-008 SHALL have ports: out_valid  out  1  out_instruction holds a word.
REQ-009 SHALL have ports: out_ready  in  1  consumer takes the word.
REQ-010 SHALL have ports: out_instruction out 32 (RV32I word), out_error out 1 (word flagged), out_count out 16 (words delivered).

Function
REQ-011 SHALL use a valid/ready handshake: transfer when valid and ready are both high on a rising edge; out_valid and output data are held stable until out_ready.
REQ-012 SHALL drive in_ready = (!out_valid || out_ready) in state SINGLE, and in_ready = 0 in state LI_HI.
REQ-013 SHALL register the encoded word one cycle after input acceptance (latency 1); back-to-back acceptance gives one word per cycle.
REQ-014 SHALL pack fields per RV32I format: R {funct7,rs2,rs1,funct3,rd,op}; I {imm[11:0],rs1,funct3,rd,op}; S {imm[11:5],rs2,rs1,funct3,imm[4:0],op}; SB {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],op}; U {imm[31:12],rd,op}; UJ {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}.
REQ-015 SHALL set out_error when the immediate is not representable: I/S imm not sign-extension of imm[11:0]; SB imm not 13-bit signed or imm[0]=1; UJ imm not 21-bit signed or imm[0]=1; U imm[11:0] != 0; the word is still emitted with truncated fields.
REQ-016 SHALL, for in_type 7, emit 32'h00000013 (NOP) with out_error=1.
REQ-017 SHALL keep out_error aligned with the word it qualifies and hold it with that word.
REQ-018 SHALL increment out_count by 1 on every output transfer, wrapping 16'hFFFF -> 16'h0000.
REQ-019 SHALL implement states SINGLE and LI_HI; SINGLE is the only state without the LI feature.

Reset
REQ-020 SHALL on rst_n=0 at a clock edge set out_valid=0, out_instruction=0, out_error=0, out_count=0, state=SINGLE.
REQ-021 SHALL abandon a pending LI second word on reset; no word appears after reset release until new input.
REQ-022 SHALL drive in_ready=0 while rst_n=0.

Configuration
REQ-023 SHALL gate LI support with macro INSTR_ENCODER_LI_EN.
REQ-024 SHALL, with INSTR_ENCODER_LI_EN defined, expand LI: if imm fits 12-bit signed, emit one ADDI rd,x0,imm (0x13, funct3 0); otherwise emit LUI rd,(imm[31:12]+imm[11]) then ADDI rd,rd,imm[11:0].
REQ-025 SHALL, in the two-word case, enter LI_HI when the LUI is loaded, load the ADDI when the LUI transfers, and return to SINGLE at that point; LI never sets out_error.
REQ-026 SHALL, without INSTR_ENCODER_LI_EN, treat in_type 6 as reserved (REQ-016).

Verification
REQ-027 SHALL cover: R add x3,x1,x2 (op 0x33, f3 0, f7 0) -> 32'h002081B3, out_error=0, one cycle after acceptance.
REQ-028 SHALL cover: SB beq x1,x2,imm=-4 (op 0x63) -> 32'hFE208EE3; the same with imm=3 -> out_error=1.
REQ-029 SHALL cover: with the LI feature, LI x5,0x12345FFF -> 32'h123462B7 then 32'hFFF28293, in_ready=0 between the two words.
REQ-030 SHALL cover: out_ready held low 5 cycles with out_valid=1 -> word stable, in_ready=0, out_count unchanged; release -> out_count+1.
REQ-031 SHALL cover: out_count preset by 65535 transfers, then one more transfer -> out_count=0.
REQ-032 SHALL cover: rst_n pulsed low while in LI_HI -> out_valid=0 after reset, no ADDI word emitted, out_count=0.
